// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 ALU sharing logic: ALU opcodes and arbiter state encoding.
package msrv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // 2'd3 is unused; the arbiter FSM falls back to IDLE from it
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/msrv32_rr_arbiter2.sv
// Two-input round-robin grant; pri names the requester that wins a tie.
module msrv32_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       pri,
  input  logic       enable,
  output logic [1:0] gnt
);

  assign gnt[0] = enable & req[0] & (~req[1] | ~pri);
  assign gnt[1] = enable & req[1] & (~req[0] |  pri);

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// Shares one combinational ALU between two requesters, with registered operands
// and a valid/ready result return to the owning requester.
//
//   state | meaning
//   IDLE  | waiting for a request, grant is live
//   EXEC  | ALU evaluating the registered operands
//   RESP  | result held for the owner until it is consumed
module msrv32_alu_arbiter
  import msrv32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPC_W = 4
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             req0_valid_in,
  input  logic [WIDTH-1:0] req0_op_1_in,
  input  logic [WIDTH-1:0] req0_op_2_in,
  input  logic [OPC_W-1:0] req0_opcode_in,
  output logic             req0_ready_out,
  input  logic             req1_valid_in,
  input  logic [WIDTH-1:0] req1_op_1_in,
  input  logic [WIDTH-1:0] req1_op_2_in,
  input  logic [OPC_W-1:0] req1_opcode_in,
  output logic             req1_ready_out,
  output logic             rsp0_valid_out,
  output logic [WIDTH-1:0] rsp0_result_out,
  input  logic             rsp0_ready_in,
  output logic             rsp1_valid_out,
  output logic [WIDTH-1:0] rsp1_result_out,
  input  logic             rsp1_ready_in,
  output logic [WIDTH-1:0] alu_op_1_out,
  output logic [WIDTH-1:0] alu_op_2_out,
  output logic [OPC_W-1:0] alu_opcode_out,
  input  logic [WIDTH-1:0] alu_result_in,
  output logic             busy_out,
  output logic             owner_out
);

  arb_state_e state;
  logic       pri;
  logic [1:0] gnt;
  logic       rsp_done;

  msrv32_rr_arbiter2 u_rr (
    .req    ({req1_valid_in, req0_valid_in}),
    .pri    (pri),
    .enable (state == ST_IDLE),
    .gnt    (gnt)
  );

  assign req0_ready_out = gnt[0];
  assign req1_ready_out = gnt[1];
  assign busy_out       = (state != ST_IDLE);

  // the non-owner's ready is deliberately ignored
  assign rsp_done = owner_out ? (rsp1_valid_out & rsp1_ready_in)
                              : (rsp0_valid_out & rsp0_ready_in);

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state           <= ST_IDLE;
      pri             <= 1'b0;
      owner_out       <= 1'b0;
      alu_op_1_out    <= '0;
      alu_op_2_out    <= '0;
      alu_opcode_out  <= '0;
      rsp0_valid_out  <= 1'b0;
      rsp1_valid_out  <= 1'b0;
      rsp0_result_out <= '0;
      rsp1_result_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt[0]) begin
            alu_op_1_out   <= req0_op_1_in;
            alu_op_2_out   <= req0_op_2_in;
            alu_opcode_out <= req0_opcode_in;
            owner_out      <= 1'b0;
            pri            <= 1'b1;
            state          <= ST_EXEC;
          end else if (gnt[1]) begin
            alu_op_1_out   <= req1_op_1_in;
            alu_op_2_out   <= req1_op_2_in;
            alu_opcode_out <= req1_opcode_in;
            owner_out      <= 1'b1;
            pri            <= 1'b0;
            state          <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (owner_out) begin
            rsp1_result_out <= alu_result_in;
            rsp1_valid_out  <= 1'b1;
          end else begin
            rsp0_result_out <= alu_result_in;
            rsp0_valid_out  <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp0_valid_out <= 1'b0;
            rsp1_valid_out <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          rsp0_valid_out <= 1'b0;
          rsp1_valid_out <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
